// File: rtl/stream_fifo_vc.sv
// Multi-channel stream FIFO: NUM_CHAN independent queues behind one write
// port and one round-robin arbitrated read port, with per-channel fill levels.
module stream_fifo_vc #(
    parameter int unsigned WIDTH     = 1,
    parameter type         T         = logic [WIDTH-1:0],
    parameter int unsigned NUM_CHAN  = 2,
    parameter int unsigned LOG_DEPTH = 3,
    localparam int unsigned CHAN_W   = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic [CHAN_W-1:0]                  src_chan_i,
    input  T                                   src_data_i,
    input  logic                               src_valid_i,
    output logic                               src_ready_o,
    output T                                   dst_data_o,
    output logic [CHAN_W-1:0]                  dst_chan_o,
    output logic                               dst_valid_o,
    input  logic                               dst_ready_i,
    output logic [NUM_CHAN-1:0][LOG_DEPTH:0]   fill_o,
    output logic [NUM_CHAN-1:0]                full_o,
    output logic [NUM_CHAN-1:0]                empty_o
);

    localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
    localparam int unsigned PTR_W = LOG_DEPTH + 1;
    localparam logic [PTR_W-1:0] FULL_XOR = PTR_W'(1) << LOG_DEPTH;

    logic [NUM_CHAN-1:0][PTR_W-1:0] wptr_q, wptr_d;
    logic [NUM_CHAN-1:0][PTR_W-1:0] rptr_q, rptr_d;
    logic [CHAN_W-1:0]              prio_q, prio_d;
    logic [CHAN_W-1:0]              lock_chan_q, lock_chan_d;
    logic                           lock_q, lock_d;

    T mem_q [NUM_CHAN][DEPTH];

    logic [CHAN_W-1:0] grant;
    logic [CHAN_W-1:0] cand;
    logic              found;
    logic              sel_ok;
    logic              sel_full;
    logic              push;
    logic              pop;

    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            fill_o[c]  = wptr_q[c] - rptr_q[c];
            empty_o[c] = (wptr_q[c] == rptr_q[c]);
            full_o[c]  = ((wptr_q[c] ^ rptr_q[c]) == FULL_XOR);
        end
    end

    // Out-of-range channel numbers match no queue and are refused.
    always_comb begin
        sel_ok   = 1'b0;
        sel_full = 1'b0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (src_chan_i == CHAN_W'(c)) begin
                sel_ok   = 1'b1;
                sel_full = full_o[c];
            end
        end
    end

    assign src_ready_o = !flush_i && sel_ok && !sel_full;
    assign push        = src_valid_i && src_ready_o;

    always_comb begin
        grant = prio_q;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            cand = CHAN_W'((int'(prio_q) + i) % NUM_CHAN);
            if (!found && !empty_o[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
        if (lock_q) begin
            grant = lock_chan_q;
        end
    end

    assign dst_valid_o = !(&empty_o) && !flush_i;
    assign dst_chan_o  = grant;
    assign dst_data_o  = mem_q[grant][rptr_q[grant][LOG_DEPTH-1:0]];
    assign pop         = dst_valid_o && dst_ready_i;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        prio_d      = prio_q;
        lock_d      = lock_q;
        lock_chan_d = lock_chan_q;
        if (flush_i) begin
            wptr_d      = '0;
            rptr_d      = '0;
            prio_d      = '0;
            lock_d      = 1'b0;
            lock_chan_d = '0;
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (push && (src_chan_i == CHAN_W'(c))) begin
                    wptr_d[c] = wptr_q[c] + PTR_W'(1);
                end
                if (pop && (grant == CHAN_W'(c))) begin
                    rptr_d[c] = rptr_q[c] + PTR_W'(1);
                end
            end
            if (pop) begin
                prio_d = (grant == CHAN_W'(NUM_CHAN - 1)) ? '0 : grant + CHAN_W'(1);
                lock_d = 1'b0;
            end else if (dst_valid_o) begin
                // Hold the offered word stable until the consumer takes it.
                lock_d      = 1'b1;
                lock_chan_d = grant;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (push && (src_chan_i == CHAN_W'(c))) begin
                mem_q[c][wptr_q[c][LOG_DEPTH-1:0]] <= src_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            prio_q      <= '0;
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            lock_chan_q <= lock_chan_d;
        end
    end

endmodule
